// File: rtl/miriscv_apb_bridge.sv
// miriscv_apb_bridge
// Turns core data-port transactions (req/gnt/rvalid) into two-phase APB
// transfers (SETUP, ACCESS). It decodes the slave index from an address
// field, waits on PREADY, and returns slave errors, decode misses and
// hang timeouts to the core as an error response.
// Only one transfer is ever outstanding.

module miriscv_apb_bridge #(
   parameter int XLEN    = 32,
   parameter int NSLV    = 2,
   parameter int SEL_LSB = 12,
   parameter int SEL_W   = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk_i,
   input  logic                 arst_i,
   // core side
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [XLEN/8-1:0]    be_i,
   input  logic [XLEN-1:0]      addr_i,
   input  logic [XLEN-1:0]      wdata_i,
   output logic                 gnt_o,
   output logic                 rvalid_o,
   output logic [XLEN-1:0]      rdata_o,
   output logic                 err_o,
   // APB side
   output logic [NSLV-1:0]      psel_o,
   output logic                 penable_o,
   output logic                 pwrite_o,
   output logic [XLEN-1:0]      paddr_o,
   output logic [XLEN-1:0]      pwdata_o,
   output logic [XLEN/8-1:0]    pstrb_o,
   input  logic [NSLV*XLEN-1:0] prdata_i,
   input  logic [NSLV-1:0]      pready_i,
   input  logic [NSLV-1:0]      pslverr_i,
   // status
   output logic [7:0]           timeout_cnt_o
);

   localparam int BW = XLEN / 8;

   // The counter value in the last ACCESS cycle before an abort. The counter
   // counts completed wait cycles, so expiry is taken one count early, and
   // the abort lands exactly after TIMEOUT cycles with PREADY low.
   localparam logic [15:0] TO_LAST = 16'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;

   logic [SEL_W-1:0]  idx_s;
   logic [NSLV-1:0]   dec_s;
   logic              dec_ok_s;

   logic [NSLV-1:0]   tgt_r;
   logic [XLEN-1:0]   sel_rdata_s;
   logic              sel_ready_s;
   logic              sel_err_s;

   logic              grant_s;
   logic              to_hit_s;
   logic [15:0]       cnt_r;
   logic [15:0]       cnt_nxt_s;
   logic [XLEN-1:0]   rdata_nxt_s;
   logic              err_nxt_s;
   logic [NSLV-1:0]   psel_nxt_s;

   logic              rvalid_r;
   logic [XLEN-1:0]   rdata_r;
   logic              err_r;
   logic [NSLV-1:0]   psel_r;
   logic              penable_r;
   logic              pwrite_r;
   logic [XLEN-1:0]   paddr_r;
   logic [XLEN-1:0]   pwdata_r;
   logic [BW-1:0]     pstrb_r;
   logic [7:0]        tcnt_r;

   assign idx_s = addr_i[SEL_LSB +: SEL_W];

   // One-hot decode of the requested slave index; indices at or beyond NSLV decode to all zeros.
   always_comb begin
      dec_s = {NSLV{1'b0}};
      for (int k = 0; k < NSLV; k++) begin
         if (idx_s == SEL_W'(k)) begin
            dec_s[k] = 1'b1;
         end else begin
            dec_s[k] = 1'b0;
         end
      end
   end

   assign dec_ok_s = |dec_s;

   // AND-OR mux of the selected slave's response; unselected slaves contribute nothing.
   always_comb begin
      sel_rdata_s = {XLEN{1'b0}};
      sel_ready_s = 1'b0;
      sel_err_s   = 1'b0;
      for (int k = 0; k < NSLV; k++) begin
         sel_rdata_s = sel_rdata_s | (prdata_i[k*XLEN +: XLEN] & {XLEN{tgt_r[k]}});
         sel_ready_s = sel_ready_s | (pready_i[k]  & tgt_r[k]);
         sel_err_s   = sel_err_s   | (pslverr_i[k] & tgt_r[k]);
      end
   end

   // Next-state, response capture and timeout decisions.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      rdata_nxt_s = rdata_r;
      err_nxt_s   = err_r;
      grant_s     = 1'b0;
      to_hit_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_i) begin
               grant_s = 1'b1;
               if (dec_ok_s) begin
                  state_nxt_s = SETUP;
               end else begin
                  // decode miss: answer with an error, never touch the bus
                  state_nxt_s = RESP;
                  rdata_nxt_s = {XLEN{1'b0}};
                  err_nxt_s   = 1'b1;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SETUP: begin
            state_nxt_s = ACCESS;
            cnt_nxt_s   = 16'd0;
         end
         ACCESS: begin
            if (sel_ready_s) begin
               // PREADY wins even in the cycle the timeout would expire
               state_nxt_s = RESP;
               rdata_nxt_s = pwrite_r ? {XLEN{1'b0}} : sel_rdata_s;
               err_nxt_s   = sel_err_s;
            end else if ((TIMEOUT != 0) && (cnt_r == TO_LAST)) begin
               state_nxt_s = RESP;
               rdata_nxt_s = {XLEN{1'b0}};
               err_nxt_s   = 1'b1;
               to_hit_s    = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + 16'd1;
            end
         end
         RESP: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // The select goes to the freshly decoded slave in SETUP and stays on the latched target through ACCESS.
   always_comb begin
      if (state_nxt_s == SETUP) begin
         psel_nxt_s = dec_s;
      end else if (state_nxt_s == ACCESS) begin
         psel_nxt_s = tgt_r;
      end else begin
         psel_nxt_s = {NSLV{1'b0}};
      end
   end

   // State and wait-cycle counter registers.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_r <= IDLE;
         cnt_r   <= 16'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Registered bus, response and status outputs; request attributes are latched at grant.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         tgt_r     <= {NSLV{1'b0}};
         psel_r    <= {NSLV{1'b0}};
         penable_r <= 1'b0;
         pwrite_r  <= 1'b0;
         paddr_r   <= {XLEN{1'b0}};
         pwdata_r  <= {XLEN{1'b0}};
         pstrb_r   <= {BW{1'b0}};
         rvalid_r  <= 1'b0;
         rdata_r   <= {XLEN{1'b0}};
         err_r     <= 1'b0;
         tcnt_r    <= 8'd0;
      end else begin
         psel_r    <= psel_nxt_s;
         penable_r <= (state_nxt_s == ACCESS);
         rvalid_r  <= (state_nxt_s == RESP);
         rdata_r   <= rdata_nxt_s;
         err_r     <= err_nxt_s;
         if (grant_s) begin
            tgt_r    <= dec_s;
            pwrite_r <= we_i;
            paddr_r  <= addr_i;
            pwdata_r <= wdata_i;
            pstrb_r  <= we_i ? be_i : {BW{1'b0}};
         end else begin
            tgt_r    <= tgt_r;
            pwrite_r <= pwrite_r;
            paddr_r  <= paddr_r;
            pwdata_r <= pwdata_r;
            pstrb_r  <= pstrb_r;
         end
         if (to_hit_s && (tcnt_r != 8'hFF)) begin
            tcnt_r <= tcnt_r + 8'd1;
         end else begin
            tcnt_r <= tcnt_r;
         end
      end
   end

   // The grant is combinational so a request is accepted in the cycle it appears; it is forced low during reset.
   assign gnt_o         = grant_s & ~arst_i;
   assign rvalid_o      = rvalid_r;
   assign rdata_o       = rdata_r;
   assign err_o         = err_r;
   assign psel_o        = psel_r;
   assign penable_o     = penable_r;
   assign pwrite_o      = pwrite_r;
   assign paddr_o       = paddr_r;
   assign pwdata_o      = pwdata_r;
   assign pstrb_o       = pstrb_r;
   assign timeout_cnt_o = tcnt_r;

endmodule

// File: tb/tb_miriscv_apb_bridge.sv
// tb_miriscv_apb_bridge
// Scoreboarded bench for the APB bridge. Each expected response is queued
// when its request is granted, and a monitor compares it when rvalid_o
// pulses, including the cycle it should arrive in.
module tb_miriscv_apb_bridge;

   logic        clk = 1'b0;
   logic        arst;
   logic        req, we;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;
   logic [1:0]  psel;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [63:0] prdata;
   logic [1:0]  pready, pslverr;
   logic [7:0]  tcnt;

   miriscv_apb_bridge #(.XLEN(32), .NSLV(2), .SEL_LSB(12), .SEL_W(2), .TIMEOUT(4)) dut (
      .clk_i(clk), .arst_i(arst),
      .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
      .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
      .pslverr_i(pslverr), .timeout_cnt_o(tcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;

   // slave model knobs: wait_n < 0 means never ready
   int          wait_n [2];
   logic        slv_err [2];
   logic [31:0] slv_rdata [2];
   int          acc [2];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Slave model: unselected slaves shout ready+error to prove they are ignored.
   always @(negedge clk) begin
      prdata = {slv_rdata[1], slv_rdata[0]};
      for (int k = 0; k < 2; k++) begin
         if (psel[k] && penable) begin
            pready[k]  = (wait_n[k] >= 0) && (acc[k] >= wait_n[k]);
            pslverr[k] = slv_err[k];
            acc[k]     = acc[k] + 1;
         end else if (psel[k]) begin
            pready[k]  = 1'b0;
            pslverr[k] = slv_err[k];
            acc[k]     = 0;
         end else begin
            pready[k]  = 1'b1;
            pslverr[k] = 1'b1;
            acc[k]     = 0;
         end
      end
   end

   // Response monitor: pop the scoreboard on each rvalid pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!arst && rvalid) begin
         if (sb.size() == 0) begin
            check_eq("spurious_rvalid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check_eq("rdata", rdata, e.rdata);
            check_eq("err", {31'd0, err}, {31'd0, e.err});
            check_eq("rvalid_cycle", cyc, e.cyc);
         end
      end
   end

   // Drive a request just after a negedge, wait (bounded) for the grant,
   // queue the expected response, return at the negedge following the grant.
   task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input int lat, input bit hold, output int gcyc);
      bit got = 1'b0;
      exp_t e;
      req = 1'b1; we = w; be = b; addr = a; wdata = d;
      #1;
      gcyc = -1;
      for (int n = 0; n < 20 && !got; n++) begin
         if (gnt) begin
            got = 1'b1;
         end else begin
            @(negedge clk);
            #1;
         end
      end
      if (!got) begin
         check_eq("gnt_timeout", 32'd0, 32'd1);
      end else begin
         gcyc = cyc;
         e.rdata = er; e.err = ee; e.cyc = cyc + lat;
         sb.push_back(e);
      end
      @(negedge clk);
      if (!hold) req = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
      if (sb.size() != 0) begin
         check_eq("resp_timeout", sb.size(), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   int g, g2;

   initial begin : wdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_n[0] = 0; wait_n[1] = 0;
      slv_err[0] = 1'b0; slv_err[1] = 1'b0;
      slv_rdata[0] = 32'hC0DE_0000; slv_rdata[1] = 32'h1234_5678;
      acc[0] = 0; acc[1] = 0;
      arst = 1'b1; req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h8000_0000; wdata = 32'h0;
      pready = 2'b00; pslverr = 2'b00; prdata = 64'd0;
      repeat (2) @(negedge clk);
      // reset state, with a request pending: no grant may leak out
      check_eq("rst_gnt", {31'd0, gnt}, 32'd0);
      check_eq("rst_psel", {30'd0, psel}, 32'd0);
      check_eq("rst_penable", {31'd0, penable}, 32'd0);
      check_eq("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check_eq("rst_paddr", paddr, 32'd0);
      check_eq("rst_tcnt", {24'd0, tcnt}, 32'd0);
      req = 1'b0;
      arst = 1'b0;
      @(negedge clk);

      // read slave 1, zero wait
      issue(1'b0, 4'hF, 32'h8000_1004, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b0, g);
      check_eq("rd_setup_psel", {30'd0, psel}, 32'd2);
      check_eq("rd_setup_pen", {31'd0, penable}, 32'd0);
      check_eq("rd_pwrite", {31'd0, pwrite}, 32'd0);
      check_eq("rd_pstrb", {28'd0, pstrb}, 32'd0);
      check_eq("rd_paddr", paddr, 32'h8000_1004);
      @(negedge clk);
      check_eq("rd_access_psel", {30'd0, psel}, 32'd2);
      check_eq("rd_access_pen", {31'd0, penable}, 32'd1);
      drain();

      // write slave 0, 3 wait cycles: ready lands on the timeout-expiry cycle and must win
      wait_n[0] = 3;
      issue(1'b1, 4'b1100, 32'h8000_0008, 32'hA5A5_0000, 32'h0, 1'b0, 6, 1'b0, g);
      for (int i = 0; i < 5; i++) begin
         check_eq("wr_psel", {30'd0, psel}, 32'd1);
         check_eq("wr_pen", {31'd0, penable}, (i == 0) ? 32'd0 : 32'd1);
         check_eq("wr_pwrite", {31'd0, pwrite}, 32'd1);
         check_eq("wr_pstrb", {28'd0, pstrb}, 32'hC);
         check_eq("wr_paddr", paddr, 32'h8000_0008);
         check_eq("wr_pwdata", pwdata, 32'hA5A5_0000);
         @(negedge clk);
      end
      drain();
      check_eq("tie_no_timeout", {24'd0, tcnt}, 32'd0);
      wait_n[0] = 0;

      // decode miss: idx 2
      issue(1'b0, 4'hF, 32'h8000_2000, 32'h0, 32'h0, 1'b1, 1, 1'b0, g);
      check_eq("dec_psel", {30'd0, psel}, 32'd0);
      drain();

      // slave error on a read still returns the read data
      slv_err[0] = 1'b1;
      issue(1'b0, 4'hF, 32'h8000_0010, 32'h0, 32'hC0DE_0000, 1'b1, 3, 1'b0, g);
      drain();
      slv_err[0] = 1'b0;

      // timeout on slave 1
      wait_n[1] = -1;
      issue(1'b0, 4'hF, 32'h8000_1000, 32'h0, 32'h0, 1'b1, 6, 1'b0, g);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("to_access_pen", {31'd0, penable}, 32'd1);
      end
      @(negedge clk);
      check_eq("to_drop_psel", {30'd0, psel}, 32'd0);
      check_eq("to_drop_pen", {31'd0, penable}, 32'd0);
      drain();
      check_eq("to_cnt_1", {24'd0, tcnt}, 32'd1);
      for (int r = 1; r < 300; r++) begin
         issue(1'b0, 4'hF, 32'h8000_1000 + 32'(r * 4), 32'h0, 32'h0, 1'b1, 6, 1'b0, g);
         drain();
      end
      check_eq("to_cnt_sat", {24'd0, tcnt}, 32'd255);

      // reset in ACCESS: bus drops immediately, no response
      issue(1'b0, 4'hF, 32'h8000_1008, 32'h0, 32'h0, 1'b1, 6, 1'b0, g);
      @(negedge clk);
      check_eq("pre_rst_pen", {31'd0, penable}, 32'd1);
      arst = 1'b1;
      #1;
      check_eq("rst_mid_psel", {30'd0, psel}, 32'd0);
      check_eq("rst_mid_pen", {31'd0, penable}, 32'd0);
      check_eq("rst_mid_tcnt", {24'd0, tcnt}, 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      arst = 1'b0;
      wait_n[1] = 0;
      repeat (3) @(negedge clk);
      issue(1'b0, 4'hF, 32'h8000_1004, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b0, g);
      drain();

      // back-to-back with req held
      issue(1'b0, 4'hF, 32'h8000_0004, 32'h0, 32'hC0DE_0000, 1'b0, 3, 1'b1, g);
      issue(1'b0, 4'hF, 32'h8000_0004, 32'h0, 32'hC0DE_0000, 1'b0, 3, 1'b0, g2);
      check_eq("b2b_gap", g2 - g, 32'd4);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
